// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver ends of uart_top.
package uart_pkg;
  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with combinational read port and separate occupancy counter.
module uart_sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             RsTx,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head entry is visible the cycle after it is written, so the reader can pop and capture on one edge.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge RsTx) begin
    if (!RsTx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser on txd.
module uart_buffered_tx
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 882,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int STOP_BITS    = 1,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1,
  localparam int BW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          RsTx,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          txd,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);
  tx_state_t                   state;
  logic [BW-1:0]               baud_cnt;
  logic [2:0]                  bit_idx;
  logic                        stop_idx;
  logic [UART_DATA_BITS-1:0]   shift_reg;
  logic [UART_DATA_BITS-1:0]   rd_data;
  logic                        fifo_full, fifo_empty;
  logic                        bit_end, last_stop, pop;

  assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  // Popping straight out of the last stop bit keeps back-to-back frames gapless.
  assign pop       = !fifo_empty &&
                     ((state == IDLE) || (state == STOP && bit_end && last_stop));
  assign in_ready  = !fifo_full;
  assign busy      = (state != IDLE);

  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk     (clk),
    .RsTx    (RsTx),
    .push    (in_valid && in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge RsTx) begin
    if (!RsTx) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= '0;
      shift_reg <= '0;
      txd       <= UART_IDLE_LEVEL;
    end else begin
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      case (state)
        IDLE: begin
          txd <= UART_IDLE_LEVEL;
          if (pop) begin
            state     <= START;
            shift_reg <= rd_data;
            txd       <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          txd     <= shift_reg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            state    <= STOP;
            stop_idx <= '0;
            txd      <= UART_IDLE_LEVEL;
          end else begin
            // txd is registered, so present the next bit as the shift happens.
            bit_idx   <= bit_idx + 3'(1);
            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            txd       <= shift_reg[1];
          end
        end
        STOP: if (bit_end) begin
          if (!last_stop) begin
            stop_idx <= stop_idx + 1'(1);
          end else if (pop) begin
            state     <= START;
            shift_reg <= rd_data;
            txd       <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
